fx_divider: RTL and testbench

Sequential radix-2 restoring divider coprocessor. It sits downstream of the DUT's instruction decoder/register file and executes that core's divide operations. It computes the two rounded fixed-point quotients the DUT must deliver: program 1 (16-bit reciprocal) and program 2 (16-bit by 8-bit quotient with 8 fractional bits). It uses a start/done handshake that mirrors the top-level DUT protocol.

---
 rtl/fx_divider.sv | 111 +++++++++++
 tb/tb_fx_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fx_divider.sv
// rtl/fx_divider.sv - radix-2 restoring divider for rounded reciprocal and scaled 16/8 quotients
module fx_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [23:0] result,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_ROUND,
        S_ZERO,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_q;
    logic [16:0] r_rem;
    logic [15:0] r_d;
    logic        r_mode;
    logic [23:0] r_result;
    logic        r_div_zero;

    logic [15:0] w_d_in;
    logic [17:0] w_shift;
    logic        w_ge;
    logic [16:0] w_diff;
    logic [15:0] w_round_m0;
    logic [23:0] w_round_m1;

    assign w_d_in = mode ? {8'h00, opb[7:0]} : opb;

    // Remainder stays below the divisor, so the shifted value fits in 17 bits and
    // the difference taken modulo 2^17 is exact whenever the trial succeeds.
    assign w_shift = {r_rem, r_q[63]};
    assign w_ge    = (w_shift >= {2'b00, r_d});
    assign w_diff  = w_shift[16:0] - {1'b0, r_d};

    assign w_round_m0 = r_q[63:48] + {15'd0, r_q[47]};
    assign w_round_m1 = r_q[63:40] + {23'd0, r_q[39]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (w_d_in == 16'd0) ? S_ZERO : S_RUN;
            S_RUN:   if (r_cnt == 6'd63) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_ZERO:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 6'd0;
            r_q        <= 64'd0;
            r_rem      <= 17'd0;
            r_d        <= 16'd0;
            r_mode     <= 1'b0;
            r_result   <= 24'h000000;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_d    <= w_d_in;
                        r_q    <= mode ? {opa, 48'd0} : 64'h8000_0000_0000_0000;
                        r_rem  <= 17'd0;
                        r_cnt  <= 6'd0;
                    end
                end
                S_RUN: begin
                    r_q   <= {r_q[62:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_shift[16:0];
                    r_cnt <= r_cnt + 6'd1;
                end
                S_ROUND: begin
                    r_result   <= r_mode ? w_round_m1 : {8'h00, w_round_m0};
                    r_div_zero <= 1'b0;
                end
                S_ZERO: begin
                    r_result   <= r_mode ? 24'hFFFFFF : 24'h00FFFF;
                    r_div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_fx_divider.sv
// tb/tb_fx_divider.sv - self-checking bench for fx_divider
module tb_fx_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [23:0] result;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    fx_divider dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [23:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer division of the effective operands, then rounding.
    function automatic logic [24:0] model(input logic m, input logic [15:0] a, input logic [15:0] b);
        logic [63:0] n;
        logic [63:0] d;
        logic [63:0] q;
        logic [23:0] r;
        n = m ? {a, 48'd0} : 64'h8000_0000_0000_0000;
        d = m ? {56'd0, b[7:0]} : {48'd0, b};
        if (d == 64'd0) return {1'b1, (m ? 24'hFFFFFF : 24'h00FFFF)};
        q = n / d;
        if (m) r = 24'(q >> 40) + 24'((q >> 39) & 64'd1);
        else   r = 24'((q >> 48) + ((q >> 47) & 64'd1));
        return {1'b0, r};
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) break;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string name, input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic [23:0] er, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        mode = m; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode = $urandom_range(0, 1); opa = 16'($urandom); opb = 16'($urandom);
        check({name, "_busy"}, busy, 1);
        lat = 1;
        if (!done) begin
            wait_done(lat);
            lat++;
        end else begin
            check({name, "_early_done"}, 0, 1);
        end
        check({name, "_lat"}, lat - 1, elat);
        check({name, "_result"}, result, er);
        check({name, "_dz"}, div_zero, edz);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_idle"}, busy, 0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [24:0] exp;
        int e, d1, dones, done_edge;
        logic [23:0] first_res;

        vecs[0] = '{1'b0, 16'h1234, 16'h0003, 24'h002AAB, 1'b0, 65};
        vecs[1] = '{1'b0, 16'h0000, 16'h0001, 24'h008000, 1'b0, 65};
        vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 24'h000001, 1'b0, 65};
        vecs[3] = '{1'b1, 16'h0001, 16'h0003, 24'h000055, 1'b0, 65};
        vecs[4] = '{1'b1, 16'h0002, 16'h0003, 24'h0000AB, 1'b0, 65};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h0001, 24'hFFFF00, 1'b0, 65};
        vecs[6] = '{1'b1, 16'h0002, 16'hFF03, 24'h0000AB, 1'b0, 65};
        vecs[7] = '{1'b1, 16'hFFFF, 16'hFF01, 24'hFFFF00, 1'b0, 65};
        vecs[8] = '{1'b0, 16'h5555, 16'h0000, 24'h00FFFF, 1'b1, 1};
        vecs[9] = '{1'b1, 16'h1234, 16'hFF00, 24'hFFFFFF, 1'b1, 1};

        reset = 1'b1; start = 1'b0; mode = 1'b0; opa = 16'd0; opb = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_dz", div_zero, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].dz, vecs[i].lat);

        for (int i = 0; i < 30; i++) begin
            logic m;
            logic [15:0] a, b;
            m = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = m ? (b & 16'hFF00) : 16'h0000;
            exp = model(m, a, b);
            do_op($sformatf("rnd%0d", i), m, a, b, exp[23:0], exp[24], exp[24] ? 1 : 65);
        end

        // Start pulses at E10 and during DONE must be ignored.
        @(negedge clk);
        mode = 1'b0; opb = 16'h0005; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0; dones = 0; done_edge = 0;
        while (e < 100) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done) begin dones++; done_edge = e; end
            start = (e == 9) || done;
            mode = 1'b1; opa = 16'hFFFF; opb = 16'h0001;
        end
        start = 1'b0;
        exp = model(1'b0, 16'h0, 16'h0005);
        check("ign_dones", dones, 1);
        check("ign_edge", done_edge, 65);
        check("ign_busy", busy, 0);
        check("ign_result", result, exp[23:0]);

        // Start held high across two operations.
        @(negedge clk);
        mode = 1'b1; opa = 16'h0002; opb = 16'h0003; start = 1'b1;
        @(posedge clk);
        e = 0; d1 = 0; first_res = 24'h0;
        while (e < 300) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (d1 == 0 && done) begin
                d1 = e;
                first_res = result;
                check("b2b_first", result, 24'h0000AB);
            end else if (d1 != 0 && e == d1 + 1) begin
                check("b2b_idle_gap", busy, 0);
                mode = 1'b0; opb = 16'h0003;
            end else if (d1 != 0 && e == d1 + 2) begin
                check("b2b_reaccept", busy, 1);
                check("b2b_prev_hold", result, first_res);
                start = 1'b0;
            end else if (d1 != 0 && done) begin
                check("b2b_lat", e - (d1 + 2), 65);
                check("b2b_second", result, 24'h002AAB);
                break;
            end
        end
        if (!done) check("b2b_timeout", 0, 1);
        repeat (5) @(negedge clk);
        check("hold_result", result, 24'h002AAB);
        check("hold_done", done, 0);

        // Reset at E30 aborts; start on the same edge loses to reset.
        @(negedge clk);
        mode = 1'b0; opb = 16'h0007; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_dz", div_zero, 0);
        reset = 1'b0; start = 1'b0;
        dones = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        exp = model(1'b0, 16'h0, 16'h0007);
        do_op("after_abort", 1'b0, 16'h0, 16'h0007, exp[23:0], 1'b0, 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
